// File: rtl/mux_pkg.sv
// Shared mode encodings and helpers for the arb_mux_n channel multiplexer.
package mux_pkg;

  localparam int unsigned MODE_SEL  = 0;  // explicit sel port
  localparam int unsigned MODE_PRIO = 1;  // fixed priority, lowest index wins
  localparam int unsigned MODE_RR   = 2;  // round-robin

  // Widest supported channel count; grant vectors are zero-extended to this.
  localparam int unsigned MAX_N = 16;

  // Index of the set bit in a one-hot (or zero) vector; zero vector yields 0.
  function automatic logic [3:0] onehot_to_idx(input logic [MAX_N-1:0] onehot);
    logic [3:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (onehot[i]) idx = idx | 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// searching cyclically; the pointer moves past the winner on each advance.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned SW = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] g_idx;

  // Cyclic search for the first request starting at the pointer.
  always_comb begin
    int unsigned idx;
    logic        found;
    grant = '0;
    g_idx = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = 32'(ptr_q) + 32'(k);
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        g_idx      = SW'(idx);
        found      = 1'b1;
      end
    end
  end

  // Pointer moves one past the granted channel, wrapping at N-1.
  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (g_idx == SW'(N - 1)) ? '0 : g_idx + 1'b1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/arb_mux_n.sv
// N-channel valid/ready multiplexer with a single registered output stage.
// Selection is explicit, fixed-priority or round-robin depending on MODE.
module arb_mux_n
  import mux_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned MODE  = 0,
  parameter int unsigned SW    = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     in_valid,
  input  logic [N*WIDTH-1:0] in_data,
  output logic [N-1:0]     in_ready,
  input  logic [SW-1:0]    sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SW-1:0]    out_src,
  input  logic             out_ready
);

  logic [N-1:0]     grant;
  logic             space;
  logic             accept;
  logic [SW-1:0]    g_idx;
  logic [WIDTH-1:0] mux_data;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  logic [SW-1:0]    src_q;

  assign space    = ~valid_q | out_ready;
  assign in_ready = grant & {N{space}};
  assign accept   = |(in_valid & in_ready);
  assign g_idx    = SW'(onehot_to_idx(MAX_N'(grant)));

  generate
    if (MODE == MODE_SEL) begin : g_sel
      // Out-of-range sel gives no grant.
      always_comb begin
        grant = '0;
        if (32'(sel) < N) grant[sel] = in_valid[sel];
      end
    end else if (MODE == MODE_PRIO) begin : g_prio
      logic unused_sel;
      assign unused_sel = ^sel;
      // Lowest-index valid channel wins.
      always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (!found && in_valid[i]) begin
            grant[i] = 1'b1;
            found    = 1'b1;
          end
        end
      end
    end else if (MODE == MODE_RR) begin : g_rr
      logic unused_sel;
      assign unused_sel = ^sel;
      rr_arbiter #(
        .N  (N),
        .SW (SW)
      ) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (in_valid),
        .advance (accept),
        .grant   (grant)
      );
    end else begin : g_none
      logic unused_sel;
      assign unused_sel = ^sel;
      assign grant = '0;
    end
  endgenerate

  // AND-OR data mux driven by the one-hot grant.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < N; i++) begin
      mux_data = mux_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
    end
  end

  // Output stage: load on accept, clear valid on drain, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
    end else if (accept) begin
      valid_q <= 1'b1;
      data_q  <= mux_data;
      src_q   <= g_idx;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_src   = src_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// Directed and randomized checks of arb_mux_n in all three selection modes.
module tb_arb_mux_n;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   in_valid;
  logic [127:0] in_data;
  logic [1:0]   sel;
  logic         out_ready;

  // Index 0: MODE0, 1: MODE1, 2: MODE2 (shared inputs, separate outputs).
  logic [3:0]   rdy [3];
  logic         ov  [3];
  logic [31:0]  od  [3];
  logic [1:0]   os  [3];

  // Separate N=5 explicit-select instance for out-of-range sel.
  logic [4:0]   v5, r5;
  logic [159:0] d5;
  logic [2:0]   s5, os5;
  logic         ov5;
  logic [31:0]  od5;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  arb_mux_n #(.N(4), .WIDTH(32), .MODE(0)) u_m0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[0]),
    .sel(sel), .out_valid(ov[0]), .out_data(od[0]), .out_src(os[0]), .out_ready(out_ready)
  );
  arb_mux_n #(.N(4), .WIDTH(32), .MODE(1)) u_m1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[1]),
    .sel(sel), .out_valid(ov[1]), .out_data(od[1]), .out_src(os[1]), .out_ready(out_ready)
  );
  arb_mux_n #(.N(4), .WIDTH(32), .MODE(2)) u_m2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data), .in_ready(rdy[2]),
    .sel(sel), .out_valid(ov[2]), .out_data(od[2]), .out_src(os[2]), .out_ready(out_ready)
  );
  arb_mux_n #(.N(5), .WIDTH(32), .MODE(0)) u_n5 (
    .clk(clk), .rst_n(rst_n), .in_valid(v5), .in_data(d5), .in_ready(r5),
    .sel(s5), .out_valid(ov5), .out_data(od5), .out_src(os5), .out_ready(1'b1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    // Load a word into every instance, then reset between clock edges.
    in_valid = 4'b0001;
    in_data  = '0;
    in_data[31:0] = 32'h1234_5678;
    sel = 2'd0;
    out_ready = 1'b0;
    step();
    n_tests++;
    if (ov[2] !== 1'b1) begin
      $display("FAIL reset_preload out_valid=%0b want 1", ov[2]);
      n_fail++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    for (int m = 0; m < 3; m++) begin
      n_tests++;
      if (ov[m] !== 1'b0 || od[m] !== 32'h0 || os[m] !== 2'd0) begin
        $display("FAIL reset_async[%0d] valid=%0b data=%h src=%0d want 0/0/0", m, ov[m], od[m],
                 os[m]);
        n_fail++;
      end
    end
    #1;
    rst_n = 1'b1;
    in_valid = 4'b0000;
  endtask

  task automatic test_sel();
    out_ready = 1'b1;
    sel = 2'd2;
    in_valid = 4'b1111;
    in_data[64 +: 32] = 32'hDEAD_BEEF;
    #1;
    n_tests++;
    if (rdy[0] !== 4'b0100) begin
      $display("FAIL sel_ready got=%b want=0100", rdy[0]);
      n_fail++;
    end
    step();
    n_tests++;
    if (ov[0] !== 1'b1 || od[0] !== 32'hDEAD_BEEF || os[0] !== 2'd2) begin
      $display("FAIL sel_out valid=%0b data=%h src=%0d want 1/deadbeef/2", ov[0], od[0], os[0]);
      n_fail++;
    end
    v5 = 5'b11111;
    d5 = '0;
    d5[128 +: 32] = 32'hCAFE_0004;
    s5 = 3'd5;
    #1;
    n_tests++;
    if (r5 !== 5'b00000) begin
      $display("FAIL sel_out_of_range got=%b want=00000", r5);
      n_fail++;
    end
    s5 = 3'd4;
    #1;
    n_tests++;
    if (r5 !== 5'b10000) begin
      $display("FAIL sel_top_index got=%b want=10000", r5);
      n_fail++;
    end
    step();
    n_tests++;
    if (ov5 !== 1'b1 || os5 !== 3'd4 || od5 !== 32'hCAFE_0004) begin
      $display("FAIL sel_top_out valid=%0b src=%0d data=%h want 1/4/cafe0004", ov5, os5, od5);
      n_fail++;
    end
    v5 = '0;
  endtask

  task automatic test_prio();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) in_data[i*32 +: 32] = 32'h1000 + 32'(i);
    in_valid = 4'b1010;
    #1;
    n_tests++;
    if (rdy[1] !== 4'b0010) begin
      $display("FAIL prio_ready1 got=%b want=0010", rdy[1]);
      n_fail++;
    end
    step();
    n_tests++;
    if (os[1] !== 2'd1 || od[1] !== 32'h1001) begin
      $display("FAIL prio_out1 src=%0d data=%h want 1/00001001", os[1], od[1]);
      n_fail++;
    end
    in_valid = 4'b1000;
    #1;
    n_tests++;
    if (rdy[1] !== 4'b1000) begin
      $display("FAIL prio_ready3 got=%b want=1000", rdy[1]);
      n_fail++;
    end
    step();
    n_tests++;
    if (os[1] !== 2'd3 || od[1] !== 32'h1003 || ov[1] !== 1'b1) begin
      $display("FAIL prio_out3 src=%0d data=%h valid=%0b want 3/00001003/1", os[1], od[1], ov[1]);
      n_fail++;
    end
    in_valid = 4'b0000;
    step();
    n_tests++;
    if (ov[1] !== 1'b0 || os[1] !== 2'd3 || od[1] !== 32'h1003) begin
      $display("FAIL prio_drain valid=%0b src=%0d data=%h want 0/3/00001003", ov[1], os[1], od[1]);
      n_fail++;
    end
  endtask

  task automatic test_rr();
    logic [1:0] exp_seq [3];
    exp_seq[0] = 2'd3;
    exp_seq[1] = 2'd0;
    exp_seq[2] = 2'd3;
    pulse_reset();
    out_ready = 1'b1;
    in_valid = 4'b1111;
    for (int k = 0; k < 9; k++) begin
      step();
      n_tests++;
      if (ov[2] !== 1'b1 || os[2] !== 2'(k % 4)) begin
        $display("FAIL rr_cycle[%0d] valid=%0b src=%0d want 1/%0d", k, ov[2], os[2], k % 4);
        n_fail++;
      end
    end
    in_valid = 4'b1001;
    for (int k = 0; k < 3; k++) begin
      step();
      n_tests++;
      if (ov[2] !== 1'b1 || os[2] !== exp_seq[k]) begin
        $display("FAIL rr_sparse[%0d] valid=%0b src=%0d want 1/%0d", k, ov[2], os[2], exp_seq[k]);
        n_fail++;
      end
    end
  endtask

  task automatic test_backpressure();
    in_valid = 4'b0000;
    out_ready = 1'b1;
    step();
    in_valid = 4'b0001;
    in_data[31:0] = 32'hAAAA_0001;
    out_ready = 1'b0;
    #1;
    n_tests++;
    if (rdy[1] !== 4'b0001) begin
      $display("FAIL bp_load_ready got=%b want=0001", rdy[1]);
      n_fail++;
    end
    step();
    in_data[31:0] = 32'hBBBB_0002;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (rdy[1] !== 4'b0000 || ov[1] !== 1'b1 || od[1] !== 32'hAAAA_0001) begin
        $display("FAIL bp_hold[%0d] ready=%b valid=%0b data=%h want 0000/1/aaaa0001", k, rdy[1],
                 ov[1], od[1]);
        n_fail++;
      end
      step();
    end
    out_ready = 1'b1;
    #1;
    n_tests++;
    if (rdy[1] !== 4'b0001) begin
      $display("FAIL bp_release_ready got=%b want=0001", rdy[1]);
      n_fail++;
    end
    step();
    n_tests++;
    if (ov[1] !== 1'b1 || od[1] !== 32'hBBBB_0002 || os[1] !== 2'd0) begin
      $display("FAIL bp_no_bubble valid=%0b data=%h src=%0d want 1/bbbb0002/0", ov[1], od[1],
               os[1]);
      n_fail++;
    end
    in_valid = 4'b0000;
  endtask

  task automatic test_random(input int m);
    logic [31:0] exp_d [$];
    logic [1:0]  exp_s [$];
    logic [3:0]  acc;
    logic [3:0]  r;
    logic        v;
    logic [31:0] d;
    logic [1:0]  s;
    logic [31:0] ed;
    logic [1:0]  es;
    in_valid = 4'b0000;
    pulse_reset();
    acc = '0;
    for (int c = 0; c < 1000; c++) begin
      // A pending request keeps its valid and data until it is accepted.
      for (int i = 0; i < 4; i++) begin
        if (!(in_valid[i] && !acc[i])) begin
          in_valid[i] = 1'($urandom_range(0, 1));
          in_data[i*32 +: 32] = $urandom;
        end
      end
      sel = 2'($urandom_range(0, 3));
      out_ready = 1'($urandom_range(0, 1));
      #1;
      r = rdy[m];
      v = ov[m];
      d = od[m];
      s = os[m];
      n_tests++;
      if ((r & (r - 4'd1)) !== 4'b0000) begin
        $display("FAIL rand_onehot0[m%0d c%0d] ready=%b want one-hot or zero", m, c, r);
        n_fail++;
      end
      n_tests++;
      if (v !== (exp_d.size() != 0)) begin
        $display("FAIL rand_valid[m%0d c%0d] valid=%0b want %0b", m, c, v, exp_d.size() != 0);
        n_fail++;
      end
      if (v && out_ready && exp_d.size() != 0) begin
        ed = exp_d.pop_front();
        es = exp_s.pop_front();
        n_tests++;
        if (d !== ed || s !== es) begin
          $display("FAIL rand_word[m%0d c%0d] data=%h src=%0d want %h/%0d", m, c, d, s, ed, es);
          n_fail++;
        end
      end
      acc = in_valid & r;
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) begin
          exp_d.push_back(in_data[i*32 +: 32]);
          exp_s.push_back(2'(i));
        end
      end
      step();
    end
    in_valid = 4'b0000;
  endtask

  initial begin
    rst_n = 1'b1;
    in_valid = '0;
    in_data = '0;
    sel = '0;
    out_ready = 1'b0;
    v5 = '0;
    d5 = '0;
    s5 = '0;
    #1;
    rst_n = 1'b0;
    #2;
    for (int m = 0; m < 3; m++) begin
      n_tests++;
      if (ov[m] !== 1'b0 || od[m] !== 32'h0 || os[m] !== 2'd0) begin
        $display("FAIL reset_init[%0d] valid=%0b data=%h src=%0d want 0/0/0", m, ov[m], od[m],
                 os[m]);
        n_fail++;
      end
    end
    rst_n = 1'b1;
    step();
    test_reset();
    test_sel();
    test_prio();
    test_rr();
    test_backpressure();
    for (int m = 0; m < 3; m++) test_random(m);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
